// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads an IMG_W x IMG_H image from a source ROM, applies
// 2x2-window commands around an operation point, then streams the result out.
module lcd_ctrl_param #(
    parameter  int DW    = 8,
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    parameter  int STEP  = 64,
    parameter  int THR   = 128,
    localparam int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] IROM_Q,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [DW-1:0] MAXV   = {DW{1'b1}};
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_MID  = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_MIN  = YW'(1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_MID  = YW'(IMG_H / 2);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        WAIT  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_r;
    state_t state_nx_s;

    logic [AW-1:0] rd_addr_r;
    logic          rd_done_r;
    logic          cap_valid_r;
    logic [AW-1:0] cap_addr_r;
    logic [3:0]    cmd_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          irb_rw_r;
    logic [AW-1:0] irb_a_r;
    logic [DW-1:0] irb_d_r;
    logic          busy_r;
    logic          done_r;
    logic [DW-1:0] pix_r [N];

    logic [XW-1:0] xm1_s;
    logic [YW-1:0] ym1_s;
    logic [AW-1:0] a_tl_s, a_tr_s, a_bl_s, a_br_s;
    logic [DW-1:0] p_tl_s, p_tr_s, p_bl_s, p_br_s;
    logic [DW-1:0] n_tl_s, n_tr_s, n_bl_s, n_br_s;
    logic [DW+1:0] sum_s;
    logic [AW-1:0] wr_next_s;

    // Brightness up, clamped at full scale.
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] p);
        logic [DW:0] s;
        s = {1'b0, p} + (DW+1)'(STEP);
        if (s > {1'b0, MAXV}) begin
            sat_add = MAXV;
        end else begin
            sat_add = s[DW-1:0];
        end
    endfunction

    // Brightness down, clamped at zero.
    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] p);
        if ({1'b0, p} < (DW+1)'(STEP)) begin
            sat_sub = {DW{1'b0}};
        end else begin
            sat_sub = p - DW'(STEP);
        end
    endfunction

    // Binarise: bright where the pixel is strictly above the threshold.
    function automatic logic [DW-1:0] bin_gt(input logic [DW-1:0] p);
        if ({1'b0, p} > (DW+1)'(THR)) begin
            bin_gt = MAXV;
        end else begin
            bin_gt = {DW{1'b0}};
        end
    endfunction

    // Binarise: bright where the pixel is strictly below the threshold.
    function automatic logic [DW-1:0] bin_lt(input logic [DW-1:0] p);
        if ({1'b0, p} < (DW+1)'(THR)) begin
            bin_lt = MAXV;
        end else begin
            bin_lt = {DW{1'b0}};
        end
    endfunction

    // The ROM is read only while load addresses are still being issued.
    assign IROM_EN = reset | (state_r != LOAD) | rd_done_r;
    assign IROM_A  = rd_addr_r;
    assign IRB_RW  = irb_rw_r;
    assign IRB_A   = irb_a_r;
    assign IRB_D   = irb_d_r;
    assign busy    = busy_r;
    assign done    = done_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; commands are taken only while waiting.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            LOAD: begin
                if (cap_valid_r && (cap_addr_r == A_LAST)) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = LOAD;
                end
            end
            WAIT: begin
                if (cmd_valid) begin
                    if (cmd == 4'h0) begin
                        state_nx_s = WRITE;
                    end else begin
                        state_nx_s = EXEC;
                    end
                end else begin
                    state_nx_s = WAIT;
                end
            end
            EXEC:    state_nx_s = WAIT;
            WRITE: begin
                if (irb_a_r == A_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = WRITE;
                end
            end
            DONE:    state_nx_s = DONE;
            default: state_nx_s = LOAD;
        endcase
    end

    // Issue load addresses and remember which address the returning data belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_r   <= {AW{1'b0}};
            rd_done_r   <= 1'b0;
            cap_valid_r <= 1'b0;
            cap_addr_r  <= {AW{1'b0}};
        end else if ((state_r == LOAD) && !rd_done_r) begin
            cap_valid_r <= 1'b1;
            cap_addr_r  <= rd_addr_r;
            if (rd_addr_r == A_LAST) begin
                rd_done_r <= 1'b1;
            end else begin
                rd_addr_r <= rd_addr_r + AW'(1);
            end
        end else begin
            cap_valid_r <= 1'b0;
        end
    end

    // Latch the command code on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_r <= 4'h0;
        end else if ((state_r == WAIT) && cmd_valid) begin
            cmd_r <= cmd;
        end
    end

    // Operation point moves, clamped to the legal window range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r <= X_MID;
            y_r <= Y_MID;
        end else if (state_r == EXEC) begin
            case (cmd_r)
                4'h1: if (y_r > Y_MIN) y_r <= y_r - YW'(1);
                4'h2: if (y_r < Y_MAX) y_r <= y_r + YW'(1);
                4'h3: if (x_r > X_MIN) x_r <= x_r - XW'(1);
                4'h4: if (x_r < X_MAX) x_r <= x_r + XW'(1);
                4'h8: begin
                    x_r <= X_MID;
                    y_r <= Y_MID;
                end
                default: ;
            endcase
        end
    end

    // Window addressing: raster address is simply {row, col}.
    always_comb begin
        xm1_s     = x_r - XW'(1);
        ym1_s     = y_r - YW'(1);
        a_tl_s    = {ym1_s, xm1_s};
        a_tr_s    = {ym1_s, x_r};
        a_bl_s    = {y_r, xm1_s};
        a_br_s    = {y_r, x_r};
        p_tl_s    = pix_r[a_tl_s];
        p_tr_s    = pix_r[a_tr_s];
        p_bl_s    = pix_r[a_bl_s];
        p_br_s    = pix_r[a_br_s];
        sum_s     = (DW+2)'(p_tl_s) + (DW+2)'(p_tr_s) + (DW+2)'(p_bl_s) + (DW+2)'(p_br_s);
        wr_next_s = irb_a_r + AW'(1);
    end

    // New window values, all derived from the pre-command pixels.
    always_comb begin
        n_tl_s = p_tl_s;
        n_tr_s = p_tr_s;
        n_bl_s = p_bl_s;
        n_br_s = p_br_s;
        case (cmd_r)
            4'h5: begin
                n_tl_s = sum_s[DW+1:2];
                n_tr_s = sum_s[DW+1:2];
                n_bl_s = sum_s[DW+1:2];
                n_br_s = sum_s[DW+1:2];
            end
            4'h6: begin
                n_tl_s = p_bl_s;
                n_tr_s = p_br_s;
                n_bl_s = p_tl_s;
                n_br_s = p_tr_s;
            end
            4'h7: begin
                n_tl_s = p_tr_s;
                n_tr_s = p_tl_s;
                n_bl_s = p_br_s;
                n_br_s = p_bl_s;
            end
            4'h9: begin
                n_tl_s = sat_add(p_tl_s);
                n_tr_s = sat_add(p_tr_s);
                n_bl_s = sat_add(p_bl_s);
                n_br_s = sat_add(p_br_s);
            end
            4'hA: begin
                n_tl_s = sat_sub(p_tl_s);
                n_tr_s = sat_sub(p_tr_s);
                n_bl_s = sat_sub(p_bl_s);
                n_br_s = sat_sub(p_br_s);
            end
            4'hB: begin
                n_tl_s = bin_gt(p_tl_s);
                n_tr_s = bin_gt(p_tr_s);
                n_bl_s = bin_gt(p_bl_s);
                n_br_s = bin_gt(p_br_s);
            end
            4'hC: begin
                n_tl_s = bin_lt(p_tl_s);
                n_tr_s = bin_lt(p_tr_s);
                n_bl_s = bin_lt(p_bl_s);
                n_br_s = bin_lt(p_br_s);
            end
            4'hD: begin
                n_tl_s = p_bl_s;
                n_tr_s = p_tl_s;
                n_br_s = p_tr_s;
                n_bl_s = p_br_s;
            end
            4'hE: begin
                n_tl_s = p_tr_s;
                n_tr_s = p_br_s;
                n_br_s = p_bl_s;
                n_bl_s = p_tl_s;
            end
            default: ;
        endcase
    end

    // Pixel store: ROM data during load, four-pixel update during execute.
    always_ff @(posedge clk) begin
        if (cap_valid_r) begin
            pix_r[cap_addr_r] <= IROM_Q;
        end else if (state_r == EXEC) begin
            pix_r[a_tl_s] <= n_tl_s;
            pix_r[a_tr_s] <= n_tr_s;
            pix_r[a_bl_s] <= n_bl_s;
            pix_r[a_br_s] <= n_br_s;
        end
    end

    // Registered status and result-port outputs, driven from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            irb_rw_r <= 1'b1;
            irb_a_r  <= {AW{1'b0}};
            irb_d_r  <= {DW{1'b0}};
        end else begin
            busy_r <= (state_nx_s != WAIT);
            done_r <= (state_nx_s == DONE);
            if (state_nx_s == WRITE) begin
                irb_rw_r <= 1'b0;
                if (state_r == WRITE) begin
                    irb_a_r <= wr_next_s;
                    irb_d_r <= pix_r[wr_next_s];
                end else begin
                    irb_a_r <= {AW{1'b0}};
                    irb_d_r <= pix_r[{AW{1'b0}}];
                end
            end else begin
                irb_rw_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: default 8x8 instance plus a
// re-parameterised 16x4, 10-bit instance.
module tb_lcd_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Default instance.
    logic       reset;
    logic [7:0] irom_q;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       irom_en;
    logic [5:0] irom_a;
    logic       irb_rw;
    logic [7:0] irb_d;
    logic [5:0] irb_a;
    logic       busy;
    logic       done;
    logic [7:0] rom   [64];
    logic [7:0] model [64];

    lcd_ctrl_param dut (
        .clk(clk), .reset(reset), .IROM_Q(irom_q), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_EN(irom_en), .IROM_A(irom_a), .IRB_RW(irb_rw), .IRB_D(irb_d),
        .IRB_A(irb_a), .busy(busy), .done(done)
    );

    // Synchronous source ROM: data one cycle after the address.
    always @(posedge clk) if (!irom_en) irom_q <= rom[irom_a];

    // Re-parameterised instance.
    logic       reset2;
    logic [9:0] irom_q2;
    logic [3:0] cmd2;
    logic       cmd_valid2;
    logic       irom_en2;
    logic [5:0] irom_a2;
    logic       irb_rw2;
    logic [9:0] irb_d2;
    logic [5:0] irb_a2;
    logic       busy2;
    logic       done2;
    logic [9:0] rom2   [64];
    logic [9:0] model2 [64];

    lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4), .STEP(100)) dut2 (
        .clk(clk), .reset(reset2), .IROM_Q(irom_q2), .cmd(cmd2), .cmd_valid(cmd_valid2),
        .IROM_EN(irom_en2), .IROM_A(irom_a2), .IRB_RW(irb_rw2), .IRB_D(irb_d2),
        .IRB_A(irb_a2), .busy(busy2), .done(done2)
    );

    // Source ROM for the second instance.
    always @(posedge clk) if (!irom_en2) irom_q2 <= rom2[irom_a2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic rom_identity();
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
    endtask

    task automatic model_from_rom();
        for (int i = 0; i < 64; i++) model[i] = rom[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_irom_en", 32'(irom_en), 32'd1);
        check("rst_irom_a",  32'(irom_a),  32'd0);
        check("rst_irb_rw",  32'(irb_rw),  32'd1);
        check("rst_irb_a",   32'(irb_a),   32'd0);
        check("rst_irb_d",   32'(irb_d),   32'd0);
        check("rst_busy",    32'(busy),    32'd1);
        check("rst_done",    32'(done),    32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called right after reset deassertion at a falling edge.
    task automatic load_check();
        int cycles;
        int cov [64];
        for (int i = 0; i < 64; i++) cov[i] = 0;
        cycles = 0;
        #1;
        while (busy === 1'b1 && cycles < 200) begin
            if (irom_en === 1'b0) cov[irom_a]++;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("load_cycles", 32'(cycles), 32'd65);
        for (int i = 0; i < 64; i++) check("load_addr_once", 32'(cov[i]), 32'd1);
        check("load_irb_rw_idle", 32'(irb_rw), 32'd1);
        check("load_done_low", 32'(done), 32'd0);
    endtask

    task automatic do_cmd(input logic [3:0] c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready", 32'(guard < 200), 32'd1);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_busy_high", 32'(busy), 32'd1);
        cmd = 4'h4;                 // stray strobe while busy
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_busy_one_cycle", 32'(busy), 32'd0);
    endtask

    // Starts the write-out and checks its first ncyc cycles.
    task automatic write_check(input int ncyc);
        @(negedge clk);
        check("wr_ready", 32'(busy), 32'd0);
        cmd       = 4'h0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd = 4'h9;                 // held strobe throughout the write
        for (int k = 0; k < ncyc; k++) begin
            check("wr_rw",   32'(irb_rw), 32'd0);
            check("wr_addr", 32'(irb_a),  32'(k));
            check("wr_data", 32'(irb_d),  32'(model[k]));
            check("wr_busy", 32'(busy),   32'd1);
            check("wr_done", 32'(done),   32'd0);
            @(negedge clk);
        end
    endtask

    task automatic done_check();
        for (int k = 0; k < 5; k++) begin
            check("done_held",  32'(done),   32'd1);
            check("done_rw",    32'(irb_rw), 32'd1);
            check("done_busy",  32'(busy),   32'd1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cycles2;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        cmd        = 4'h0;
        cmd_valid  = 1'b0;
        reset2     = 1'b1;
        cmd2       = 4'h0;
        cmd_valid2 = 1'b0;

        // Load timing, abort mid-load, clockwise rotation, full write-out.
        rom_identity();
        rom[27] = 8'd1; rom[28] = 8'd2; rom[35] = 8'd3; rom[36] = 8'd4;
        do_reset();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midload_irom_en", 32'(irom_en), 32'd1);
        check("midload_irom_a",  32'(irom_a),  32'd0);
        check("midload_busy",    32'(busy),    32'd1);
        @(negedge clk);
        reset = 1'b0;
        load_check();
        do_cmd(4'hD);
        model_from_rom();
        model[27] = 8'd3; model[28] = 8'd1; model[35] = 8'd4; model[36] = 8'd2;
        write_check(64);
        done_check();

        // Point reset, rotate round trip, no-op, row swap; abort mid-write.
        do_reset();
        load_check();
        do_cmd(4'h4);
        do_cmd(4'h8);
        do_cmd(4'hD);
        do_cmd(4'hE);
        do_cmd(4'hF);
        do_cmd(4'h6);
        model_from_rom();
        write_check(5);
        reset = 1'b1;
        #1;
        check("midwr_irb_rw", 32'(irb_rw), 32'd1);
        check("midwr_irb_a",  32'(irb_a),  32'd0);
        check("midwr_irb_d",  32'(irb_d),  32'd0);
        check("midwr_done",   32'(done),   32'd0);
        check("midwr_busy",   32'(busy),   32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b0;
        load_check();
        do_cmd(4'hD);
        do_cmd(4'hE);
        do_cmd(4'hF);
        do_cmd(4'h6);
        model[27] = 8'd3; model[28] = 8'd4; model[35] = 8'd1; model[36] = 8'd2;
        write_check(64);
        done_check();

        // y saturates at 1, brightness up saturates at 255.
        rom_identity();
        rom[3] = 8'd200; rom[4] = 8'd250; rom[11] = 8'd10; rom[12] = 8'd0;
        do_reset();
        load_check();
        for (int i = 0; i < 5; i++) do_cmd(4'h1);
        do_cmd(4'h9);
        model_from_rom();
        model[3] = 8'd255; model[4] = 8'd255; model[11] = 8'd74; model[12] = 8'd64;
        write_check(64);
        done_check();

        // Average, brightness down, both thresholds, column swap.
        rom_identity();
        rom[27] = 8'd255; rom[28] = 8'd255; rom[35] = 8'd255; rom[36] = 8'd254;
        rom[29] = 8'd30;  rom[30] = 8'd64;  rom[37] = 8'd65;  rom[38] = 8'd200;
        rom[13] = 8'd128; rom[14] = 8'd129; rom[21] = 8'd127; rom[22] = 8'd0;
        rom[9]  = 8'd128; rom[10] = 8'd129; rom[17] = 8'd127; rom[18] = 8'd255;
        do_reset();
        load_check();
        do_cmd(4'h5);
        do_cmd(4'h4);
        do_cmd(4'h4);
        do_cmd(4'hA);
        do_cmd(4'h1);
        do_cmd(4'h1);
        do_cmd(4'hB);
        for (int i = 0; i < 4; i++) do_cmd(4'h3);
        do_cmd(4'hC);
        do_cmd(4'h7);
        model_from_rom();
        model[27] = 8'd254; model[28] = 8'd254; model[35] = 8'd254; model[36] = 8'd254;
        model[29] = 8'd0;   model[30] = 8'd0;   model[37] = 8'd1;   model[38] = 8'd136;
        model[13] = 8'd0;   model[14] = 8'd255; model[21] = 8'd0;   model[22] = 8'd0;
        model[9]  = 8'd0;   model[10] = 8'd0;   model[17] = 8'd0;   model[18] = 8'd255;
        write_check(64);
        done_check();

        // 16x4, 10-bit instance: point (8,2) window is addresses 23,24,39,40.
        for (int i = 0; i < 64; i++) rom2[i] = 10'(i);
        rom2[40] = 10'd1000;
        for (int i = 0; i < 64; i++) model2[i] = rom2[i];
        model2[23] = 10'd123; model2[24] = 10'd124; model2[39] = 10'd139; model2[40] = 10'd1023;
        @(negedge clk);
        check("p_rst_busy", 32'(busy2), 32'd1);
        reset2  = 1'b0;
        cycles2 = 0;
        #1;
        while (busy2 === 1'b1 && cycles2 < 200) begin
            @(posedge clk);
            #1;
            cycles2++;
        end
        check("p_load_cycles", 32'(cycles2), 32'd65);
        @(negedge clk);
        cmd2       = 4'h9;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        check("p_busy_high", 32'(busy2), 32'd1);
        @(negedge clk);
        check("p_busy_low", 32'(busy2), 32'd0);
        cmd2       = 4'h0;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check("p_wr_rw",   32'(irb_rw2), 32'd0);
            check("p_wr_addr", 32'(irb_a2),  32'(k));
            check("p_wr_data", 32'(irb_d2),  32'(model2[k]));
            @(negedge clk);
        end
        check("p_done", 32'(done2), 32'd1);
        check("p_rw_idle", 32'(irb_rw2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
